window_3x3_gen: RTL and testbench

//  Consumer end of the 3x3 line-buffer interface. Takes the per-column vertical taps
//  (top/mid/bot rows) from line_buffer_3x3 and shifts them horizontally into a full 3x3 window.

---
 rtl/window_3x3_gen.sv | 114 +++++++++++
 tb/tb_window_3x3_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// 3x3 window former: shifts per-column vertical taps into a 3x3 window
// and strobes windows that lie inside the image and on the stride grid.
module window_3x3_gen #(
  parameter int DATA_W     = 16,
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64,
  parameter int STRIDE     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic [DATA_W-1:0]             col_top,
  input  logic [DATA_W-1:0]             col_mid,
  input  logic [DATA_W-1:0]             col_bot,
  input  logic                          col_valid,
  output logic [9*DATA_W-1:0]           win_out,
  output logic                          win_valid,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  if (STRIDE != 1 && STRIDE != 2) begin : g_bad_stride
    $error("window_3x3_gen: STRIDE must be 1 or 2");
  end

  logic [DATA_W-1:0] win_q [9];
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [CW-1:0]     c_off;
  logic [RW-1:0]     r_off;
  logic [CW-1:0]     c_out;
  logic [RW-1:0]     r_out;
  logic              c_grid;
  logic              r_grid;
  logic              col_last;
  logic              row_last;
  logic              win_hit;

  assign c_off    = col_cnt - CW'(2);
  assign r_off    = row_cnt - RW'(2);
  assign col_last = (col_cnt == CW'(IMG_WIDTH - 1));
  assign row_last = (row_cnt == RW'(IMG_HEIGHT - 1));

  // Stride 2: grid test is the LSB of the offset, coordinate is a shift.
  if (STRIDE == 2) begin : g_s2
    assign c_grid = ~c_off[0];
    assign r_grid = ~r_off[0];
    assign c_out  = c_off >> 1;
    assign r_out  = r_off >> 1;
  end else begin : g_s1
    assign c_grid = 1'b1;
    assign r_grid = 1'b1;
    assign c_out  = c_off;
    assign r_out  = r_off;
  end

  assign win_hit = (col_cnt >= CW'(2)) && (row_cnt >= RW'(2))
                 && c_grid && r_grid;

  always_comb begin
    win_out = '0;
    for (int i = 0; i < 9; i++)
      win_out[i*DATA_W +: DATA_W] = win_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      win_valid  <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (col_valid) begin
        for (int r = 0; r < 3; r++) begin
          win_q[3*r]   <= win_q[3*r+1];
          win_q[3*r+1] <= win_q[3*r+2];
        end
        win_q[2] <= col_top;
        win_q[5] <= col_mid;
        win_q[8] <= col_bot;
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= row_last ? '0 : row_cnt + RW'(1);
        end else begin
          col_cnt <= col_cnt + CW'(1);
        end
        win_valid  <= win_hit;
        frame_done <= col_last && row_last;
        if (win_hit) begin
          out_row <= r_out;
          out_col <= c_out;
        end
      end
    end
  end

endmodule

// File: tb/tb_window_3x3_gen.sv
// Randomized bench for window_3x3_gen: stride-1 and stride-2 instances
// driven in parallel, checked against an image-level window model.
module tb_window_3x3_gen;

  localparam int DW = 16;
  localparam int W  = 8;
  localparam int H  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          col_valid;
  logic [DW-1:0] col_top, col_mid, col_bot;

  logic [9*DW-1:0] win1, win2;
  logic            wv1, wv2;
  logic [2:0]      or1, or2, oc1, oc2;
  logic            fd1, fd2;

  int total = 0;
  int bad   = 0;
  int mr, mc;
  int eor1, eoc1, eor2, eoc2;
  int n1, n2, nf1, nf2;

  always #5 clk = ~clk;

  window_3x3_gen #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .col_valid(col_valid), .win_out(win1), .win_valid(wv1),
    .out_row(or1), .out_col(oc1), .frame_done(fd1));

  window_3x3_gen #(.DATA_W(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .STRIDE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .col_top(col_top), .col_mid(col_mid), .col_bot(col_bot),
    .col_valid(col_valid), .win_out(win2), .win_valid(wv2),
    .out_row(or2), .out_col(oc2), .frame_done(fd2));

  task automatic chk(input string tag, input logic [159:0] obs,
                     input logic [159:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int r, input int c);
    return DW'(16 * r + c);
  endfunction

  function automatic bit hit(input int s, input int r, input int c);
    return r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0;
  endfunction

  // Window straight from the image: element (i,j) is pixel (r-2+i, c-2+j).
  function automatic logic [9*DW-1:0] win_of(input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = pix(r - 2 + i, c - 2 + j);
    return w;
  endfunction

  task automatic model_restart();
    mr = 0; mc = 0;
    eor1 = 0; eoc1 = 0; eor2 = 0; eoc2 = 0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_d1"}, 160'({win1, wv1, or1, oc1, fd1}), '0);
    chk({tag, "_d2"}, 160'({win2, wv2, or2, oc2, fd2}), '0);
  endtask

  task automatic step(input logic v, input logic clr);
    logic h1, h2, fd;
    logic [9*DW-1:0] w;
    @(negedge clk);
    col_valid = v;
    clear     = clr;
    col_top   = (v && mr >= 2) ? pix(mr - 2, mc) : DW'($urandom);
    col_mid   = (v && mr >= 1) ? pix(mr - 1, mc) : DW'($urandom);
    col_bot   = v ? pix(mr, mc) : DW'($urandom);
    h1 = 1'b0; h2 = 1'b0; fd = 1'b0; w = '0;
    if (clr) begin
      model_restart();
    end else if (v) begin
      h1 = hit(1, mr, mc);
      h2 = hit(2, mr, mc);
      fd = (mr == H - 1) && (mc == W - 1);
      if (h1) begin
        w = win_of(mr, mc);
        eor1 = mr - 2; eoc1 = mc - 2;
      end
      if (h2) begin
        eor2 = (mr - 2) / 2; eoc2 = (mc - 2) / 2;
      end
      mc++;
      if (mc == W) begin
        mc = 0;
        mr = (mr == H - 1) ? 0 : mr + 1;
      end
    end
    @(posedge clk);
    #1;
    chk("valid1", 160'(wv1), 160'(h1));
    chk("valid2", 160'(wv2), 160'(h2));
    chk("fdone1", 160'(fd1), 160'(fd));
    chk("fdone2", 160'(fd2), 160'(fd));
    chk("pos1", 160'({or1, oc1}), 160'({3'(eor1), 3'(eoc1)}));
    chk("pos2", 160'({or2, oc2}), 160'({3'(eor2), 3'(eoc2)}));
    if (h1) chk("win1", 160'(win1), 160'(w));
    if (h2) chk("win2", 160'(win2), 160'(w));
    if (wv1) n1++;
    if (wv2) n2++;
    if (fd1) nf1++;
    if (fd2) nf2++;
  endtask

  task automatic zero_counts();
    n1 = 0; n2 = 0; nf1 = 0; nf2 = 0;
  endtask

  task automatic run_cols(input int n, input int duty);
    int acc;
    acc = 0;
    while (acc < n) begin
      if ($urandom_range(0, 99) < duty) begin
        step(1'b1, 1'b0);
        acc++;
      end else begin
        step(1'b0, 1'b0);
      end
    end
  endtask

  task automatic check_counts(input string tag, input int e1, input int e2,
                              input int ef);
    chk({tag, "_n1"}, 160'(n1), 160'(e1));
    chk({tag, "_n2"}, 160'(n2), 160'(e2));
    chk({tag, "_fd1"}, 160'(nf1), 160'(ef));
    chk({tag, "_fd2"}, 160'(nf2), 160'(ef));
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; col_valid = 1'b0;
    col_top = '0; col_mid = '0; col_bot = '0;
    model_restart();
    zero_counts();
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a frame while inputs keep toggling.
    run_cols(27, 100);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("rst_async");
    repeat (3) begin
      @(negedge clk);
      col_valid = ~col_valid;
      col_top = DW'($urandom);
      @(posedge clk);
      #1 check_zero("rst_hold");
    end
    @(negedge clk);
    col_valid = 1'b0;
    rst_n = 1'b1;
    model_restart();

    zero_counts();
    run_cols(W * H, 100);
    check_counts("cont", 36, 9, 1);
    repeat (3) step(1'b0, 1'b0);

    zero_counts();
    run_cols(W * H, 30);
    check_counts("gap", 36, 9, 1);

    zero_counts();
    run_cols(2 * W * H, 100);
    check_counts("b2b", 72, 18, 2);

    // clear collides with the column at (row 3, col 4); that column is lost.
    zero_counts();
    run_cols(3 * W + 4, 100);
    step(1'b1, 1'b1);
    chk("clr_pos", 160'({wv1, wv2, or1, oc1}), '0);
    zero_counts();
    run_cols(W * H, 70);
    check_counts("clr", 36, 9, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
